// File: rtl/bram_frame_reader_pkg.sv
// bram_frame_reader_pkg
// Shared types and sizing helpers for the BRAM frame reader.
//   state_t    : reader FSM states
//   tag_t      : per-pixel frame/line markers carried alongside each read
//   min1_clog2 : ceil(log2(n)) clamped to at least one bit
//   FIFO_PTR_W : pointer width of the default-depth output buffer
package bram_frame_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } tag_t;

   // Counter/pointer widths must never collapse to zero bits for tiny sizes.
   function automatic int min1_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int FIFO_PTR_W     = min1_clog2(DEF_FIFO_DEPTH);

endpackage

// File: rtl/bram_frame_reader_if.sv
// bram_frame_reader_if
// Valid/ready pixel stream leaving the frame reader.
//   valid/ready : handshake, a pixel moves when both are high on a clock edge
//   data        : pixel value
//   sof/eol/eof : first pixel of frame, last pixel of line, last pixel of frame
// Modports: master (reader side), slave (downstream consumer).
interface bram_frame_reader_if #(
   parameter int RAM_WIDTH = 8
) ();

   logic                 valid;
   logic                 ready;
   logic [RAM_WIDTH-1:0] data;
   logic                 sof;
   logic                 eol;
   logic                 eof;

   modport master (output valid, data, sof, eol, eof, input ready);
   modport slave  (input valid, data, sof, eol, eof, output ready);

endinterface

// File: rtl/bram_reader_fifo.sv
// bram_reader_fifo
// Small synchronous first-word-fall-through FIFO: the head entry is visible on
// rd_data whenever the FIFO is not empty, and rd_en pops it.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (accepted when not full, or when popping same cycle)
//   rd_en      : pop head (ignored when empty)
//   rd_data    : head entry
//   empty      : no entries
//   count      : number of stored entries, 0..DEPTH
module bram_reader_fifo
   import bram_frame_reader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int PTR_W = FIFO_PTR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_rd   = rd_en && (count != '0);
   assign do_wr   = wr_en && ((count != (PTR_W+1)'(DEPTH)) || do_rd);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage is cleared on reset so the head reads as zero while empty
   // after reset, keeping the stream data output at a defined value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_rd) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
      end
   end

endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader
// Reads one IMG_W x IMG_H frame out of a BRAM port starting at base_addr and
// streams it as valid/ready pixels. Reads are issued one per cycle while the
// output buffer plus the reads still in the BRAM pipeline leave room, so a
// stalled consumer can never overflow the buffer and no pixel is lost.
// Optional feature macro: BRAM_FRAME_READER_MARKERS_EN
//   defined   : column/row counters produce sof/eol/eof per pixel
//   undefined : markers tied low, frame end found by a pixel down-counter
// Ports:
//   clka, rsta  : clock (shared with BRAM port), asynchronous active-low reset
//   start       : request one frame, honoured only when idle
//   base_addr   : first pixel address, captured with an accepted start
//   busy, done  : frame in progress; one-cycle completion pulse
//   bram_en/we/regce/addr, bram_dout : BRAM read port
//   m           : pixel stream (master side)
module bram_frame_reader
   import bram_frame_reader_pkg::*;
#(
   parameter int RAM_WIDTH  = 8,
   parameter int ADDR_W     = 19,
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clka,
   input  logic                     rsta,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     bram_en,
   output logic                     bram_we,
   output logic                     bram_regce,
   output logic [ADDR_W-1:0]        bram_addr,
   input  logic [RAM_WIDTH-1:0]     bram_dout,
   bram_frame_reader_if.master      m
);

   localparam int CNT_W = min1_clog2(FIFO_DEPTH) + 1;

`ifdef BRAM_FRAME_READER_MARKERS_EN
   localparam int FIFO_W = RAM_WIDTH + 3;
   localparam int COL_W  = min1_clog2(IMG_W);
   localparam int ROW_W  = min1_clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
`else
   localparam int FIFO_W = RAM_WIDTH;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int PIX_W  = min1_clog2(NPIX + 1);
`endif

   state_t                  state;
   logic                    busy_q;
   logic                    done_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [CNT_W-1:0]        inflight;
   logic [RD_LATENCY-1:0]   tag_vld;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;
   logic [FIFO_W-1:0]       fifo_wdata;
   logic [FIFO_W-1:0]       fifo_rdata;
   logic [CNT_W:0]          occupancy;
   logic                    issue;
   logic                    last_issue;
   logic                    tag_exit;
   logic                    pop;
   logic                    drain_done;

`ifdef BRAM_FRAME_READER_MARKERS_EN
   logic [COL_W-1:0]            col;
   logic [ROW_W-1:0]            row;
   tag_t                        tag_in;
   tag_t [RD_LATENCY-1:0]       tag_sr;
`else
   logic [PIX_W-1:0]            remaining;
`endif

   // Buffer entries plus reads still inside the BRAM pipeline bound what may
   // still land in the FIFO; issuing only below FIFO_DEPTH guarantees space.
   assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
   assign issue      = (state == RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
   assign tag_exit   = tag_vld[RD_LATENCY-1];
   assign pop        = m.valid & m.ready;
   // Look one cycle ahead so done lands the cycle after the final pop.
   assign drain_done = (inflight == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

`ifdef BRAM_FRAME_READER_MARKERS_EN
   assign last_issue = issue && (col == COL_LAST) && (row == ROW_LAST);
   assign tag_in.sof = (col == '0) && (row == '0);
   assign tag_in.eol = (col == COL_LAST);
   assign tag_in.eof = (col == COL_LAST) && (row == ROW_LAST);
   assign fifo_wdata = {tag_sr[RD_LATENCY-1], bram_dout};
   assign m.sof      = fifo_rdata[RAM_WIDTH+2];
   assign m.eol      = fifo_rdata[RAM_WIDTH+1];
   assign m.eof      = fifo_rdata[RAM_WIDTH];
`else
   assign last_issue = issue && (remaining == PIX_W'(1));
   assign fifo_wdata = bram_dout;
   assign m.sof      = 1'b0;
   assign m.eol      = 1'b0;
   assign m.eof      = 1'b0;
`endif

   assign m.data     = fifo_rdata[RAM_WIDTH-1:0];
   assign m.valid    = ~fifo_empty;
   assign bram_en    = issue;
   assign bram_addr  = addr_q;
   assign bram_we    = 1'b0;
   assign bram_regce = 1'b1;
   assign busy       = busy_q;
   assign done       = done_q;

   // Frame control: FSM, read address, issue-tag pipeline that mirrors the
   // BRAM latency, and the pixel position counters. An async reset drops
   // every tag, so reads already in the BRAM are simply never captured.
   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         inflight <= '0;
         tag_vld  <= '0;
`ifdef BRAM_FRAME_READER_MARKERS_EN
         tag_sr   <= '0;
         col      <= '0;
         row      <= '0;
`else
         remaining <= '0;
`endif
      end else begin
         done_q     <= 1'b0;
         tag_vld[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld[i] <= tag_vld[i-1];
         end
         inflight <= inflight + CNT_W'(issue) - CNT_W'(tag_exit);
         if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
`ifdef BRAM_FRAME_READER_MARKERS_EN
         tag_sr[0] <= issue ? tag_in : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
         end
         if (issue) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
`else
         if (issue) begin
            remaining <= remaining - PIX_W'(1);
         end
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  addr_q <= base_addr;
`ifdef BRAM_FRAME_READER_MARKERS_EN
                  col    <= '0;
                  row    <= '0;
`else
                  remaining <= PIX_W'(NPIX);
`endif
               end
            end
            RUN: begin
               if (last_issue) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   bram_reader_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH),
      .PTR_W (CNT_W - 1)
   ) u_fifo (
      .clk     (clka),
      .rst_n   (rsta),
      .wr_en   (tag_exit),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader
// Three reader instances share one clock and reset:
//   index 0 : 4x2 frame, index 1 : 2x2 frame, index 2 : 1x1 frame.
// Each has its own 2-cycle BRAM model holding mem[i] = i & 0xFF.
module tb_bram_frame_reader;

`ifdef BRAM_FRAME_READER_MARKERS_EN
   localparam bit MARK_EN = 1'b1;
`else
   localparam bit MARK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rsta;
   logic [2:0]  start_v, busy_v, done_v, en_v, we_v, regce_v;
   logic [2:0]  ready_v, valid_v, sof_v, eol_v, eof_v;
   logic [18:0] base_v  [3];
   logic [18:0] addr_v  [3];
   logic [7:0]  dout_v  [3];
   logic [7:0]  stage_v [3];
   logic [7:0]  data_v  [3];
   logic [7:0]  mem     [1024];

   int passed = 0;
   int total  = 0;

   // Results gathered by applyStimulus for the calling test to judge.
   logic [7:0]  got_data [$];
   logic [2:0]  got_mark [$];
   int          got_cyc  [$];
   int          done_cnt, done_cyc, last_acc, first_en_cyc;
   logic [18:0] first_addr;
   bit          occ_bad, timed_out;

   bram_frame_reader_if #(.RAM_WIDTH(8)) if_a ();
   bram_frame_reader_if #(.RAM_WIDTH(8)) if_b ();
   bram_frame_reader_if #(.RAM_WIDTH(8)) if_c ();

   assign if_a.ready = ready_v[0];
   assign if_b.ready = ready_v[1];
   assign if_c.ready = ready_v[2];
   assign valid_v = {if_c.valid, if_b.valid, if_a.valid};
   assign sof_v   = {if_c.sof, if_b.sof, if_a.sof};
   assign eol_v   = {if_c.eol, if_b.eol, if_a.eol};
   assign eof_v   = {if_c.eof, if_b.eof, if_a.eof};
   assign data_v[0] = if_a.data;
   assign data_v[1] = if_b.data;
   assign data_v[2] = if_c.data;

   bram_frame_reader #(.RAM_WIDTH(8), .ADDR_W(19), .IMG_W(4), .IMG_H(2),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
      .clka(clk), .rsta(rsta), .start(start_v[0]), .base_addr(base_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .bram_en(en_v[0]), .bram_we(we_v[0]),
      .bram_regce(regce_v[0]), .bram_addr(addr_v[0]), .bram_dout(dout_v[0]),
      .m(if_a));

   bram_frame_reader #(.RAM_WIDTH(8), .ADDR_W(19), .IMG_W(2), .IMG_H(2),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_b (
      .clka(clk), .rsta(rsta), .start(start_v[1]), .base_addr(base_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .bram_en(en_v[1]), .bram_we(we_v[1]),
      .bram_regce(regce_v[1]), .bram_addr(addr_v[1]), .bram_dout(dout_v[1]),
      .m(if_b));

   bram_frame_reader #(.RAM_WIDTH(8), .ADDR_W(19), .IMG_W(1), .IMG_H(1),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_c (
      .clka(clk), .rsta(rsta), .start(start_v[2]), .base_addr(base_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .bram_en(en_v[2]), .bram_we(we_v[2]),
      .bram_regce(regce_v[2]), .bram_addr(addr_v[2]), .bram_dout(dout_v[2]),
      .m(if_c));

   // BRAM in output-register mode: address stage then output register.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (en_v[k]) stage_v[k] <= mem[addr_v[k][9:0]];
         if (regce_v[k]) dout_v[k] <= stage_v[k];
      end
   end

   // Expected {sof, eol, eof} for pixel i of a w-wide frame of n pixels.
   function automatic logic [2:0] exp_mark(input int i, input int w, input int n);
      return MARK_EN ? {i == 0, (i % w) == (w - 1), i == (n - 1)} : 3'b000;
   endfunction

   // Runs one frame on instance k from the start cycle (c = 0) onward,
   // sampling at the falling edge. mode 1 drives ready as 1,0,0,1 repeating.
   // restart_cyc re-pulses start; reset_after asserts reset once that many
   // pixels have been accepted.
   task automatic applyStimulus(input int k, input logic [18:0] b, input int mode,
                                input int restart_cyc, input int reset_after);
      int c, issued, popped;
      bit stop;
      got_data.delete();
      got_mark.delete();
      got_cyc.delete();
      done_cnt = 0; done_cyc = -1; last_acc = -1; first_en_cyc = -1;
      first_addr = '0; occ_bad = 1'b0; timed_out = 1'b0;
      c = 0; issued = 0; popped = 0; stop = 1'b0;
      while (!stop) begin
         @(negedge clk);
         if (reset_after > 0 && popped == reset_after) begin
            rsta       = 1'b0;
            start_v[k] = 1'b0;
            ready_v[k] = 1'b0;
            stop       = 1'b1;
         end else begin
            ready_v[k] = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
            start_v[k] = (c == 0) || (c == restart_cyc);
            base_v[k]  = (c == 0) ? b : b + 19'd50;
            if (en_v[k]) begin
               if (issued - popped >= 4) occ_bad = 1'b1;
               if (first_en_cyc < 0) begin
                  first_en_cyc = c;
                  first_addr   = addr_v[k];
               end
               issued++;
            end
            if (valid_v[k] && ready_v[k]) begin
               got_data.push_back(data_v[k]);
               got_mark.push_back({sof_v[k], eol_v[k], eof_v[k]});
               got_cyc.push_back(c);
               popped++;
               last_acc = c;
            end
            if (done_v[k]) begin
               done_cnt++;
               if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) stop = 1'b1;
            else if (c >= 200) begin
               timed_out = 1'b1;
               stop      = 1'b1;
            end
            c++;
         end
      end
      start_v[k] = 1'b0;
      ready_v[k] = 1'b0;
   endtask

   task automatic test_reset();
      rsta = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy_v[0], done_v[0], en_v[0], valid_v[0], sof_v[0], eol_v[0], eof_v[0],
           we_v[0], regce_v[0]} !== 9'b000000001)
         $display("[TB] FAIL reset_ctrl got %b expected %b",
                  {busy_v[0], done_v[0], en_v[0], valid_v[0], sof_v[0], eol_v[0],
                   eof_v[0], we_v[0], regce_v[0]}, 9'b000000001);
      else passed++;
      total++;
      if (addr_v[0] !== 19'd0) $display("[TB] FAIL reset_addr got %0d expected 0", addr_v[0]);
      else passed++;
      total++;
      if (data_v[0] !== 8'd0) $display("[TB] FAIL reset_data got %0d expected 0", data_v[0]);
      else passed++;
      rsta = 1'b1;
   endtask

   task automatic test_basic();
      applyStimulus(0, 19'd0, 0, -1, 0);
      total++;
      if (timed_out) $display("[TB] FAIL basic_timeout got timeout expected done");
      else passed++;
      total++;
      if (got_data.size() !== 8) $display("[TB] FAIL basic_count got %0d expected 8", got_data.size());
      else passed++;
      total++;
      if (first_en_cyc !== 1 || first_addr !== 19'd0)
         $display("[TB] FAIL basic_first_issue got cyc %0d addr %0d expected cyc 1 addr 0",
                  first_en_cyc, first_addr);
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 8'(i)) $display("[TB] FAIL basic_data[%0d] got %0d expected %0d", i, got_data[i], i);
         else passed++;
         total++;
         if (got_mark[i] !== exp_mark(i, 4, 8))
            $display("[TB] FAIL basic_mark[%0d] got %b expected %b", i, got_mark[i], exp_mark(i, 4, 8));
         else passed++;
         total++;
         if (got_cyc[i] !== 4 + i) $display("[TB] FAIL basic_cycle[%0d] got %0d expected %0d", i, got_cyc[i], 4 + i);
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 12)
         $display("[TB] FAIL basic_done got count %0d cyc %0d expected count 1 cyc 12", done_cnt, done_cyc);
      else passed++;
      total++;
      if (occ_bad) $display("[TB] FAIL basic_occupancy got issue at 4 outstanding expected none");
      else passed++;
   endtask

   task automatic test_backpressure();
      applyStimulus(0, 19'd0, 1, -1, 0);
      total++;
      if (got_data.size() !== 8 || timed_out)
         $display("[TB] FAIL bp_count got %0d (timeout %0d) expected 8", got_data.size(), timed_out);
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 8'(i)) $display("[TB] FAIL bp_data[%0d] got %0d expected %0d", i, got_data[i], i);
         else passed++;
         total++;
         if (got_mark[i] !== exp_mark(i, 4, 8))
            $display("[TB] FAIL bp_mark[%0d] got %b expected %b", i, got_mark[i], exp_mark(i, 4, 8));
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== last_acc + 1)
         $display("[TB] FAIL bp_done got count %0d cyc %0d expected count 1 cyc %0d",
                  done_cnt, done_cyc, last_acc + 1);
      else passed++;
      total++;
      if (occ_bad) $display("[TB] FAIL bp_occupancy got issue at 4 outstanding expected none");
      else passed++;
   endtask

   task automatic test_base_addr();
      applyStimulus(1, 19'd100, 0, -1, 0);
      total++;
      if (first_addr !== 19'd100) $display("[TB] FAIL base_first_addr got %0d expected 100", first_addr);
      else passed++;
      total++;
      if (got_data.size() !== 4) $display("[TB] FAIL base_count got %0d expected 4", got_data.size());
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 8'(100 + i))
            $display("[TB] FAIL base_data[%0d] got %0d expected %0d", i, got_data[i], 100 + i);
         else passed++;
         total++;
         if (got_mark[i] !== exp_mark(i, 2, 4))
            $display("[TB] FAIL base_mark[%0d] got %b expected %b", i, got_mark[i], exp_mark(i, 2, 4));
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 8)
         $display("[TB] FAIL base_done got count %0d cyc %0d expected count 1 cyc 8", done_cnt, done_cyc);
      else passed++;
   endtask

   task automatic test_restart_ignored();
      applyStimulus(0, 19'd0, 0, 5, 0);
      total++;
      if (got_data.size() !== 8) $display("[TB] FAIL restart_count got %0d expected 8", got_data.size());
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 8'(i)) $display("[TB] FAIL restart_data[%0d] got %0d expected %0d", i, got_data[i], i);
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 12)
         $display("[TB] FAIL restart_done got count %0d cyc %0d expected count 1 cyc 12", done_cnt, done_cyc);
      else passed++;
   endtask

   task automatic test_reset_mid_frame();
      applyStimulus(0, 19'd0, 0, -1, 3);
      #1;
      total++;
      if (got_data.size() !== 3) $display("[TB] FAIL midrst_accepted got %0d expected 3", got_data.size());
      else passed++;
      total++;
      if ({busy_v[0], done_v[0], en_v[0], valid_v[0], sof_v[0], eol_v[0], eof_v[0]} !== 7'b0)
         $display("[TB] FAIL midrst_ctrl got %b expected 0000000",
                  {busy_v[0], done_v[0], en_v[0], valid_v[0], sof_v[0], eol_v[0], eof_v[0]});
      else passed++;
      total++;
      if (addr_v[0] !== 19'd0 || data_v[0] !== 8'd0)
         $display("[TB] FAIL midrst_addr_data got addr %0d data %0d expected 0 0", addr_v[0], data_v[0]);
      else passed++;
      @(negedge clk);
      rsta = 1'b1;
      applyStimulus(0, 19'd0, 0, -1, 0);
      total++;
      if (got_data.size() !== 8) $display("[TB] FAIL midrst_rerun_count got %0d expected 8", got_data.size());
      else passed++;
      for (int i = 0; i < got_data.size(); i++) begin
         total++;
         if (got_data[i] !== 8'(i)) $display("[TB] FAIL midrst_rerun_data[%0d] got %0d expected %0d", i, got_data[i], i);
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 12)
         $display("[TB] FAIL midrst_rerun_done got count %0d cyc %0d expected count 1 cyc 12", done_cnt, done_cyc);
      else passed++;
   endtask

   task automatic test_single_pixel();
      applyStimulus(2, 19'd7, 0, -1, 0);
      total++;
      if (got_data.size() !== 1) $display("[TB] FAIL single_count got %0d expected 1", got_data.size());
      else passed++;
      if (got_data.size() > 0) begin
         total++;
         if (got_data[0] !== 8'd7) $display("[TB] FAIL single_data got %0d expected 7", got_data[0]);
         else passed++;
         total++;
         if (got_mark[0] !== exp_mark(0, 1, 1))
            $display("[TB] FAIL single_mark got %b expected %b", got_mark[0], exp_mark(0, 1, 1));
         else passed++;
         total++;
         if (got_cyc[0] !== 4) $display("[TB] FAIL single_cycle got %0d expected 4", got_cyc[0]);
         else passed++;
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 5)
         $display("[TB] FAIL single_done got count %0d cyc %0d expected count 1 cyc 5", done_cnt, done_cyc);
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i & 8'hFF);
      rsta    = 1'b0;
      start_v = '0;
      ready_v = '0;
      for (int k = 0; k < 3; k++) base_v[k] = '0;
      $display("[TB] bram_frame_reader bench, markers enabled = %0d", MARK_EN);
      test_reset();
      test_basic();
      test_backpressure();
      test_base_addr();
      test_restart_ignored();
      test_reset_mid_frame();
      test_single_pixel();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
